dino_sprite_rom: RTL and testbench

- Responder side of the dino layer's sprite-ROM interface.
- Accepts the 6-bit pixel address {row[2:0], col[2:0]} from the dino layer and returns the 1-bit sprite colour in the same cycle.
- Internally selects one of five 8x8 bitmaps with an animation state machine. The state machine is advanced once per video frame from game-state inputs (run, jump, duck, dead).
- Sits between the game logic and the dino layer inside the render top level.

---
 rtl/dino_sprite_pkg.sv | 34 +++
 rtl/dino_sprite_rom_if.sv | 21 ++
 rtl/dino_anim_fsm.sv | 107 ++++++++++
 rtl/dino_sprite_rom.sv | 48 ++++
 tb/tb_dino_sprite_rom.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dino_sprite_pkg.sv
// Shared definitions for the dino sprite ROM: frame indices, states, bitmaps.
// Each bitmap packs row 0 into bits [63:56], so pixel (y,x) sits at bit 63-addr.
package dino_sprite_pkg;

  localparam logic [2:0] FRAME_RUN_A = 3'd0;
  localparam logic [2:0] FRAME_RUN_B = 3'd1;
  localparam logic [2:0] FRAME_JUMP  = 3'd2;
  localparam logic [2:0] FRAME_DUCK  = 3'd3;
  localparam logic [2:0] FRAME_DEAD  = 3'd4;

  // State encoding equals the frame index it displays.
  typedef enum logic [2:0] {
    ST_RUN_A = 3'd0,
    ST_RUN_B = 3'd1,
    ST_JUMP  = 3'd2,
    ST_DUCK  = 3'd3,
    ST_DEAD  = 3'd4
  } anim_state_e;

  localparam logic [63:0] BM_RUN_A = 64'h0E0B_0F8C_FC78_4840;
  localparam logic [63:0] BM_RUN_B = 64'h0E0B_0F8C_FC78_4808;
  localparam logic [63:0] BM_JUMP  = 64'h0E0B_0F8C_FC78_8800;
  localparam logic [63:0] BM_DUCK  = 64'h0000_000E_8BFF_7E24;
  localparam logic [63:0] BM_DEAD  = 64'h0E15_0F8C_FC78_4848;

  // ROW[y][7-x] with y=addr[5:3], x=addr[2:0] collapses to bit 63-addr.
  function automatic logic bm_pixel(
    input logic [63:0] bm,
    input logic [5:0]  addr
  );
    return bm[6'd63 - addr];
  endfunction

endpackage

// File: rtl/dino_sprite_rom_if.sv
// Sprite-ROM bus between the dino layer / game logic and the sprite ROM.
// master drives address and game-state inputs; slave returns colour and index.
interface dino_sprite_rom_if;
  logic [5:0] i_addr;
  logic       o_color;
  logic       i_frame_tick;
  logic       i_jump;
  logic       i_duck;
  logic       i_dead;
  logic [2:0] o_frame_idx;

  modport master (
    output i_addr, i_frame_tick, i_jump, i_duck, i_dead,
    input  o_color, o_frame_idx
  );

  modport slave (
    input  i_addr, i_frame_tick, i_jump, i_duck, i_dead,
    output o_color, o_frame_idx
  );
endinterface

// File: rtl/dino_anim_fsm.sv
// Dino animation FSM: state, leg-swap counter, optional DEAD blink (DINO_BLINK_EN).
// Ports: clk, rst, i_frame_tick, i_jump, i_duck, i_dead -> o_frame_idx, o_blink.
module dino_anim_fsm
  import dino_sprite_pkg::*;
#(
  parameter int ANIM_DIV  = 6,
  parameter int BLINK_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_frame_tick,
  input  logic       i_jump,
  input  logic       i_duck,
  input  logic       i_dead,
  output logic [2:0] o_frame_idx,
  output logic       o_blink
);

  if (ANIM_DIV < 1 || ANIM_DIV > 63 ||
      BLINK_DIV < 1 || BLINK_DIV > 63) begin : g_bad_param
    $error("dino_anim_fsm: divider out of range 1..63");
  end

  localparam logic [5:0] ANIM_LAST = 6'(ANIM_DIV - 1);

  anim_state_e state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN_A;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (i_frame_tick) begin
      cnt_d = 6'd0;
      if (i_dead) begin
        state_d = ST_DEAD;
      end else if (i_jump) begin
        state_d = ST_JUMP;
      end else if (i_duck) begin
        state_d = ST_DUCK;
      end else if (state_q == ST_RUN_A ||
                   state_q == ST_RUN_B) begin
        if (cnt_q == ANIM_LAST) begin
          state_d = (state_q == ST_RUN_A) ? ST_RUN_B
                                          : ST_RUN_A;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end else begin
        state_d = ST_RUN_A;
      end
    end
  end

  assign o_frame_idx = state_q;

`ifdef DINO_BLINK_EN
  localparam logic [5:0] BLINK_LAST = 6'(BLINK_DIV - 1);

  logic [5:0] bcnt_q, bcnt_d;
  logic       blink_q, blink_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_q  <= 6'd0;
      blink_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
    end
  end

  // Counting starts on the tick after DEAD entry, so the
  // first BLINK_DIV frames of DEAD show the sprite.
  always_comb begin
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    if (i_frame_tick) begin
      if (i_dead && state_q == ST_DEAD) begin
        if (bcnt_q == BLINK_LAST) begin
          bcnt_d  = 6'd0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d = bcnt_q + 6'd1;
        end
      end else begin
        bcnt_d  = 6'd0;
        blink_d = 1'b0;
      end
    end
  end

  assign o_blink = blink_q;
`else
  assign o_blink = 1'b0;
`endif

endmodule

// File: rtl/dino_sprite_rom.sv
// Dino sprite ROM: zero-latency bitmap lookup under the animation FSM.
// Ports: clk, rst, bus (slave: i_addr, i_frame_tick, i_jump, i_duck, i_dead
// -> o_color, o_frame_idx). Optional DEAD blinking via DINO_BLINK_EN.
module dino_sprite_rom
  import dino_sprite_pkg::*;
#(
  parameter int ANIM_DIV  = 6,
  parameter int BLINK_DIV = 8
) (
  input  logic              clk,
  input  logic              rst,
  dino_sprite_rom_if.slave  bus
);

  logic [2:0] frame_idx;
  logic       blink;
  logic       pix;

  dino_anim_fsm #(
    .ANIM_DIV  (ANIM_DIV),
    .BLINK_DIV (BLINK_DIV)
  ) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .i_frame_tick (bus.i_frame_tick),
    .i_jump       (bus.i_jump),
    .i_duck       (bus.i_duck),
    .i_dead       (bus.i_dead),
    .o_frame_idx  (frame_idx),
    .o_blink      (blink)
  );

  always_comb begin
    pix = 1'b0;
    case (frame_idx)
      FRAME_RUN_A: pix = bm_pixel(BM_RUN_A, bus.i_addr);
      FRAME_RUN_B: pix = bm_pixel(BM_RUN_B, bus.i_addr);
      FRAME_JUMP:  pix = bm_pixel(BM_JUMP,  bus.i_addr);
      FRAME_DUCK:  pix = bm_pixel(BM_DUCK,  bus.i_addr);
      FRAME_DEAD:  pix = bm_pixel(BM_DEAD,  bus.i_addr);
      default:     pix = 1'b0;
    endcase
  end

  assign bus.o_color     = pix & ~blink;
  assign bus.o_frame_idx = frame_idx;

endmodule

// File: tb/tb_dino_sprite_rom.sv
// Self-checking bench for dino_sprite_rom (ANIM_DIV=6, BLINK_DIV=8).
// Expected frame indices / colours are queued on drive and popped on sample.
module tb_dino_sprite_rom;
  import dino_sprite_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dino_sprite_rom_if bus ();

  dino_sprite_rom #(
    .ANIM_DIV  (6),
    .BLINK_DIV (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int npass  = 0;
  int ntotal = 0;

  logic [2:0] idx_q[$];
  logic       col_q[$];

  logic [2:0] e_idx;
  logic       e_col;

  // Independent pixel lookup: row y at [63-8y -: 8], pixel = row[7-x].
  function automatic logic ref_pix(input logic [63:0] bm, input int a);
    logic [7:0] row;
    int y, x;
    y = a / 8;
    x = a % 8;
    row = bm[63 - 8*y -: 8];
    return row[7 - x];
  endfunction

  task automatic tick_drive(input logic j, input logic d,
                            input logic dd, input logic [2:0] e);
    @(negedge clk);
    bus.i_jump       = j;
    bus.i_duck       = d;
    bus.i_dead       = dd;
    bus.i_frame_tick = 1'b1;
    idx_q.push_back(e);
    @(negedge clk);
    bus.i_frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_addr = 6'd0;
    bus.i_frame_tick = 1'b0;
    bus.i_jump = 1'b0;
    bus.i_duck = 1'b0;
    bus.i_dead = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 64; a++) begin
      bus.i_addr = 6'(a);
      col_q.push_back(ref_pix(BM_RUN_A, a));
      #1;
      e_col = col_q.pop_front();
      ntotal++;
      if (bus.o_color !== e_col)
        $display("FAIL reset_color addr=%0d got %b want %b",
                 a, bus.o_color, e_col);
      else npass++;
    end
    idx_q.push_back(3'd0);
    e_idx = idx_q.pop_front();
    ntotal++;
    if (bus.o_frame_idx !== e_idx)
      $display("FAIL reset_idx got %0d want %0d", bus.o_frame_idx, e_idx);
    else npass++;
  endtask

  task automatic test_run();
    bus.i_addr = 6'd57;
    for (int k = 1; k <= 12; k++) begin
      tick_drive(1'b0, 1'b0, 1'b0, (k >= 6 && k < 12) ? 3'd1 : 3'd0);
      e_idx = idx_q.pop_front();
      ntotal++;
      if (bus.o_frame_idx !== e_idx)
        $display("FAIL run_tick%0d got %0d want %0d",
                 k, bus.o_frame_idx, e_idx);
      else npass++;
      if (k == 6) begin
        for (int h = 0; h < 3; h++) begin
          @(negedge clk);
          idx_q.push_back(3'd1);
          e_idx = idx_q.pop_front();
          ntotal++;
          if (bus.o_frame_idx !== e_idx)
            $display("FAIL run_hold%0d got %0d want %0d",
                     h, bus.o_frame_idx, e_idx);
          else npass++;
        end
        col_q.push_back(ref_pix(BM_RUN_B, 57));
        e_col = col_q.pop_front();
        ntotal++;
        if (bus.o_color !== e_col)
          $display("FAIL run_b_color got %b want %b", bus.o_color, e_col);
        else npass++;
      end
    end
  endtask

  task automatic test_jump_duck();
    tick_drive(1'b1, 1'b1, 1'b0, 3'd2);
    tick_drive(1'b0, 1'b1, 1'b0, 3'd3);
    tick_drive(1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 1; k <= 6; k++)
      tick_drive(1'b0, 1'b0, 1'b0, (k == 6) ? 3'd1 : 3'd0);
    for (int k = 0; k < 9; k++) begin
      e_idx = idx_q.pop_front();
      ntotal++;
      // Results are checked after the sequence; all land in the final idx.
      if (k == 8 && bus.o_frame_idx !== e_idx)
        $display("FAIL jd_final got %0d want %0d", bus.o_frame_idx, e_idx);
      else if (k == 8) npass++;
      else ntotal--;
    end
  endtask

  task automatic test_jump_duck_steps();
    logic [2:0] exp_seq[4];
    exp_seq[0] = 3'd2;
    exp_seq[1] = 3'd3;
    exp_seq[2] = 3'd0;
    exp_seq[3] = 3'd2;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: tick_drive(1'b1, 1'b1, 1'b0, exp_seq[k]);
        1: tick_drive(1'b0, 1'b1, 1'b0, exp_seq[k]);
        2: tick_drive(1'b0, 1'b0, 1'b0, exp_seq[k]);
        default: tick_drive(1'b1, 1'b0, 1'b0, exp_seq[k]);
      endcase
      e_idx = idx_q.pop_front();
      ntotal++;
      if (bus.o_frame_idx !== e_idx)
        $display("FAIL jd_step%0d got %0d want %0d",
                 k, bus.o_frame_idx, e_idx);
      else npass++;
    end
  endtask

  task automatic test_dead();
    tick_drive(1'b1, 1'b0, 1'b1, 3'd4);
    for (int k = 0; k < 10; k++)
      tick_drive(1'b0, 1'b0, 1'b1, 3'd4);
    tick_drive(1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 12; k++) begin
      e_idx = idx_q.pop_front();
      ntotal++;
      if (k == 11 && bus.o_frame_idx !== e_idx)
        $display("FAIL dead_exit got %0d want %0d", bus.o_frame_idx, e_idx);
      else if (k == 11) npass++;
      else ntotal--;
    end
  endtask

  task automatic test_blink();
    bus.i_addr = 6'd4;
    for (int k = 0; k <= 20; k++) begin
      tick_drive(1'b0, 1'b0, 1'b1, 3'd4);
`ifdef DINO_BLINK_EN
      col_q.push_back(((k / 8) % 2 == 0) ? ref_pix(BM_DEAD, 4) : 1'b0);
`else
      col_q.push_back(ref_pix(BM_DEAD, 4));
`endif
      e_idx = idx_q.pop_front();
      e_col = col_q.pop_front();
      ntotal++;
      if (bus.o_frame_idx !== e_idx)
        $display("FAIL blink_idx%0d got %0d want %0d",
                 k, bus.o_frame_idx, e_idx);
      else npass++;
      ntotal++;
      if (bus.o_color !== e_col)
        $display("FAIL blink_color%0d got %b want %b",
                 k, bus.o_color, e_col);
      else npass++;
    end
    tick_drive(1'b0, 1'b0, 1'b0, 3'd0);
    col_q.push_back(ref_pix(BM_RUN_A, 4));
    e_idx = idx_q.pop_front();
    e_col = col_q.pop_front();
    ntotal++;
    if (bus.o_frame_idx !== e_idx || bus.o_color !== e_col)
      $display("FAIL blink_exit got %0d/%b want %0d/%b",
               bus.o_frame_idx, bus.o_color, e_idx, e_col);
    else npass++;
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 9; k++) begin
      tick_drive(1'b0, 1'b0, 1'b0, (k >= 6) ? 3'd1 : 3'd0);
      e_idx = idx_q.pop_front();
      ntotal++;
      if (bus.o_frame_idx !== e_idx)
        $display("FAIL arst_pre%0d got %0d want %0d",
                 k, bus.o_frame_idx, e_idx);
      else npass++;
    end
    @(negedge clk);
    #2 rst = 1'b1;
    idx_q.push_back(3'd0);
    #1;
    e_idx = idx_q.pop_front();
    ntotal++;
    if (bus.o_frame_idx !== e_idx)
      $display("FAIL arst_async got %0d want %0d", bus.o_frame_idx, e_idx);
    else npass++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick_drive(1'b0, 1'b0, 1'b0, (k == 6) ? 3'd1 : 3'd0);
      e_idx = idx_q.pop_front();
      ntotal++;
      if (bus.o_frame_idx !== e_idx)
        $display("FAIL arst_post%0d got %0d want %0d",
                 k, bus.o_frame_idx, e_idx);
      else npass++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_run();
    test_jump_duck();
    test_jump_duck_steps();
    test_dead();
    test_blink();
    test_async_reset();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
